// File: rtl/hex_display_stream_decoder.sv
// Receive-side decoder for the HCMS hex dot-matrix serial stream.
// Snoops the display pins, rebuilds the control word and the dot frame,
// and maps each 40-dot character back to the hex nibble it shows.
module hex_display_stream_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_CHARS   = 16
) (
   input  logic                   clock_27mhz,
   input  logic                   reset,
   input  logic                   disp_clock,
   input  logic                   disp_data_out,
   input  logic                   disp_rs,
   input  logic                   disp_ce_b,
   input  logic                   disp_reset_b,
   output logic [4*NUM_CHARS-1:0] data,
   output logic [31:0]            control,
   output logic                   frame_valid,
   output logic                   frame_err,
   output logic                   blank_seen,
   output logic                   ctrl_valid,
   output logic                   ctrl_err
);

   localparam int              DW         = 4 * NUM_CHARS;
   localparam int              CW         = $clog2(NUM_CHARS + 1);
   localparam logic [CW-1:0]   CHARS_FULL = CW'(NUM_CHARS);

   typedef enum logic [1:0] {S_IDLE, S_DOT, S_CTRL} state_t;

   // Column-major 5x8 glyphs as emitted by the labkit hex driver, dot 39 first.
   function automatic logic [39:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 40'b00111110_01010001_01001001_01000101_00111110;
         4'h1: glyph = 40'b00000000_01000010_01111111_01000000_00000000;
         4'h2: glyph = 40'b01100010_01010001_01001001_01001001_01000110;
         4'h3: glyph = 40'b00100010_01000001_01001001_01001001_00110110;
         4'h4: glyph = 40'b00011000_00010100_00010010_01111111_00010000;
         4'h5: glyph = 40'b00100111_01000101_01000101_01000101_00111001;
         4'h6: glyph = 40'b00111100_01001010_01001001_01001001_00110000;
         4'h7: glyph = 40'b00000001_01110001_00001001_00000101_00000011;
         4'h8: glyph = 40'b00110110_01001001_01001001_01001001_00110110;
         4'h9: glyph = 40'b00000110_01001001_01001001_00101001_00011110;
         4'hA: glyph = 40'b01111110_00001001_00001001_00001001_01111110;
         4'hB: glyph = 40'b01111111_01001001_01001001_01001001_00110110;
         4'hC: glyph = 40'b00111110_01000001_01000001_01000001_00100010;
         4'hD: glyph = 40'b01111111_01000001_01000001_01000001_00111110;
         4'hE: glyph = 40'b01111111_01001001_01001001_01001001_01000001;
         4'hF: glyph = 40'b01111111_00001001_00001001_00001001_00000001;
      endcase
   endfunction

   // Pin order inside the synchronizer vector: {reset_b, ce_b, rs, data, clock}.
   logic [4:0] pins;
   logic [4:0] sync_q [SYNC_STAGES+1];
   logic [4:0] cur, dly;
   logic       clk_rise, ce_rise, shift_en, bit_s, rs_s, rst_b_s;

   assign pins = {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, disp_clock};

   // Synchronizer chain; the last element is the edge-detect register.
   always_ff @(posedge clock_27mhz) begin
      // NOTE: non-blocking assignments keep every stage sampling its neighbour's old value.
      if (reset) begin
         for (int i = 0; i <= SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i <= SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign cur      = sync_q[SYNC_STAGES-1];
   assign dly      = sync_q[SYNC_STAGES];
   assign clk_rise = cur[0] & ~dly[0];
   assign ce_rise  = cur[3] & ~dly[3];
   // A shift is accepted while chip enable was low, even if it rises this very cycle.
   assign shift_en = clk_rise & ~dly[3];
   assign bit_s    = dly[1];
   assign rs_s     = dly[2];
   assign rst_b_s  = dly[4];

   state_t          state_q;
   logic [5:0]      bit_cnt_q, bit_cnt_d, bit_cnt_eff;
   logic [5:0]      ctrl_cnt_q, ctrl_cnt_d, ctrl_cnt_eff;
   logic [CW-1:0]   char_cnt_q, char_cnt_d;
   logic [39:0]     char_sr_q, char_sr_d;
   logic [31:0]     ctrl_sr_q, ctrl_sr_d, ctrl_sr_eff;
   logic [DW-1:0]   stage_q, stage_d, data_q;
   logic [31:0]     control_q;
   logic            dec_pend_q, bad_q, bad_d, blank_q, blank_d, glyph_q, glyph_d;
   logic            dec_hit, last_bit, commit_ok;
   logic [3:0]      dec_nib;
   int              slot;
   logic            frame_valid_q, frame_err_q, blank_seen_q, ctrl_valid_q, ctrl_err_q;

   // Character decode (folded in the cycle after dot 0) and shift/counter next values.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      dec_hit    = 1'b0;
      dec_nib    = '0;
      for (int g = 0; g < 16; g++) begin
         if (char_sr_q == glyph(4'(g))) begin
            dec_hit = 1'b1;
            dec_nib = 4'(g);
         end
      end
      slot       = NUM_CHARS - 1 - int'(char_cnt_q);
      char_cnt_d = char_cnt_q;
      bad_d      = bad_q;
      blank_d    = blank_q;
      glyph_d    = glyph_q;
      stage_d    = stage_q;
      if (dec_pend_q) begin
         if (char_cnt_q == CHARS_FULL) begin
            bad_d = 1'b1;
         end else begin
            if (dec_hit) begin
               stage_d[4*slot +: 4] = dec_nib;
               glyph_d              = 1'b1;
            end else if (char_sr_q == '0) begin
               blank_d = 1'b1;
            end else begin
               bad_d = 1'b1;
            end
            char_cnt_d = char_cnt_q + 1'b1;
         end
      end
      char_sr_d    = {char_sr_q[38:0], bit_s};
      last_bit     = (bit_cnt_q == 6'd39);
      bit_cnt_d    = last_bit ? 6'd0 : bit_cnt_q + 1'b1;
      ctrl_sr_d    = {ctrl_sr_q[30:0], bit_s};
      ctrl_cnt_d   = (ctrl_cnt_q == 6'd33) ? ctrl_cnt_q : ctrl_cnt_q + 1'b1;
      bit_cnt_eff  = shift_en ? bit_cnt_d  : bit_cnt_q;
      ctrl_cnt_eff = shift_en ? ctrl_cnt_d : ctrl_cnt_q;
      ctrl_sr_eff  = shift_en ? ctrl_sr_d  : ctrl_sr_q;
      commit_ok    = (char_cnt_d == CHARS_FULL) && (bit_cnt_eff == 6'd0) && !bad_d;
   end

   // Transfer FSM: shifts, commit checks and registered result pulses.
   always_ff @(posedge clock_27mhz) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         ctrl_cnt_q    <= '0;
         char_cnt_q    <= '0;
         char_sr_q     <= '0;
         ctrl_sr_q     <= '0;
         stage_q       <= '0;
         dec_pend_q    <= 1'b0;
         bad_q         <= 1'b0;
         blank_q       <= 1'b0;
         glyph_q       <= 1'b0;
         data_q        <= '0;
         control_q     <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         blank_seen_q  <= 1'b0;
         ctrl_valid_q  <= 1'b0;
         ctrl_err_q    <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         blank_seen_q  <= 1'b0;
         ctrl_valid_q  <= 1'b0;
         ctrl_err_q    <= 1'b0;
         if (!rst_b_s) begin
            // Display reset drops any partial transfer; committed data/control are kept.
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            ctrl_cnt_q <= '0;
            char_cnt_q <= '0;
            char_sr_q  <= '0;
            ctrl_sr_q  <= '0;
            stage_q    <= '0;
            dec_pend_q <= 1'b0;
            bad_q      <= 1'b0;
            blank_q    <= 1'b0;
            glyph_q    <= 1'b0;
         end else begin
            char_cnt_q <= char_cnt_d;
            bad_q      <= bad_d;
            blank_q    <= blank_d;
            glyph_q    <= glyph_d;
            stage_q    <= stage_d;
            dec_pend_q <= 1'b0;
            case (state_q)
               S_IDLE: begin
                  if (shift_en) begin
                     if (rs_s) begin
                        state_q    <= S_CTRL;
                        ctrl_sr_q  <= ctrl_sr_d;
                        ctrl_cnt_q <= ctrl_cnt_d;
                     end else begin
                        state_q    <= S_DOT;
                        char_sr_q  <= char_sr_d;
                        bit_cnt_q  <= bit_cnt_d;
                     end
                  end
               end
               S_DOT: begin
                  if (shift_en) begin
                     char_sr_q  <= char_sr_d;
                     bit_cnt_q  <= bit_cnt_d;
                     dec_pend_q <= last_bit;
                  end
                  if (ce_rise) begin
                     if (commit_ok && !glyph_d) begin
                        blank_seen_q <= 1'b1;
                     end else if (commit_ok && !blank_d) begin
                        data_q        <= stage_d;
                        frame_valid_q <= 1'b1;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                     state_q    <= S_IDLE;
                     bit_cnt_q  <= '0;
                     char_cnt_q <= '0;
                     char_sr_q  <= '0;
                     stage_q    <= '0;
                     dec_pend_q <= 1'b0;
                     bad_q      <= 1'b0;
                     blank_q    <= 1'b0;
                     glyph_q    <= 1'b0;
                  end
               end
               S_CTRL: begin
                  if (shift_en) begin
                     ctrl_sr_q  <= ctrl_sr_d;
                     ctrl_cnt_q <= ctrl_cnt_d;
                  end
                  if (ce_rise) begin
                     if (ctrl_cnt_eff == 6'd32) begin
                        control_q    <= ctrl_sr_eff;
                        ctrl_valid_q <= 1'b1;
                     end else begin
                        ctrl_err_q <= 1'b1;
                     end
                     state_q    <= S_IDLE;
                     ctrl_cnt_q <= '0;
                     ctrl_sr_q  <= '0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data        = data_q;
   assign control     = control_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign blank_seen  = blank_seen_q;
   assign ctrl_valid  = ctrl_valid_q;
   assign ctrl_err    = ctrl_err_q;

endmodule

// File: tb/tb_hex_display_stream_decoder.sv
// Directed bench: a serial BFM mimics the labkit hex driver, expected result
// pulses go into a scoreboard queue and are popped when the decoder pulses.
module tb_hex_display_stream_decoder;

   logic        clk = 1'b0;
   logic        reset, disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b;
   logic [63:0] data;
   logic [31:0] control;
   logic        frame_valid, frame_err, blank_seen, ctrl_valid, ctrl_err;

   always #5 clk = ~clk;

   hex_display_stream_decoder #(.SYNC_STAGES(2), .NUM_CHARS(16)) dut (
      .clock_27mhz  (clk),
      .reset        (reset),
      .disp_clock   (disp_clock),
      .disp_data_out(disp_data_out),
      .disp_rs      (disp_rs),
      .disp_ce_b    (disp_ce_b),
      .disp_reset_b (disp_reset_b),
      .data         (data),
      .control      (control),
      .frame_valid  (frame_valid),
      .frame_err    (frame_err),
      .blank_seen   (blank_seen),
      .ctrl_valid   (ctrl_valid),
      .ctrl_err     (ctrl_err)
   );

   typedef enum int {EV_NONE, EV_CTRL, EV_CTRL_ERR, EV_FRAME, EV_FRAME_ERR, EV_BLANK} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [63:0] val;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pulses_seen = 0;
   int          snap;
   logic [63:0] exp_data;
   logic [31:0] exp_ctrl;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [63:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   // Independent copy of the labkit glyph table (dot 39 first).
   function automatic logic [39:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 40'b00111110_01010001_01001001_01000101_00111110;
         4'h1: glyph = 40'b00000000_01000010_01111111_01000000_00000000;
         4'h2: glyph = 40'b01100010_01010001_01001001_01001001_01000110;
         4'h3: glyph = 40'b00100010_01000001_01001001_01001001_00110110;
         4'h4: glyph = 40'b00011000_00010100_00010010_01111111_00010000;
         4'h5: glyph = 40'b00100111_01000101_01000101_01000101_00111001;
         4'h6: glyph = 40'b00111100_01001010_01001001_01001001_00110000;
         4'h7: glyph = 40'b00000001_01110001_00001001_00000101_00000011;
         4'h8: glyph = 40'b00110110_01001001_01001001_01001001_00110110;
         4'h9: glyph = 40'b00000110_01001001_01001001_00101001_00011110;
         4'hA: glyph = 40'b01111110_00001001_00001001_00001001_01111110;
         4'hB: glyph = 40'b01111111_01001001_01001001_01001001_00110110;
         4'hC: glyph = 40'b00111110_01000001_01000001_01000001_00100010;
         4'hD: glyph = 40'b01111111_01000001_01000001_01000001_00111110;
         4'hE: glyph = 40'b01111111_01001001_01001001_01001001_01000001;
         4'hF: glyph = 40'b01111111_00001001_00001001_00001001_00000001;
      endcase
   endfunction

   // Scoreboard consumer: every result pulse must match the head of the queue.
   task automatic take(input ev_kind_t k, input string name, input logic [63:0] v);
      ev_t e;
      pulses_seen++;
      if (exp_q.size() == 0) begin
         check({"unexpected_", name}, 64'(k), 64'(EV_NONE));
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, 64'(k), 64'(e.kind));
         check({name, "_value"}, v, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (ctrl_valid)  take(EV_CTRL,      "ctrl_valid",  {32'h0, control});
         if (ctrl_err)    take(EV_CTRL_ERR,  "ctrl_err",    {32'h0, control});
         if (frame_valid) take(EV_FRAME,     "frame_valid", data);
         if (frame_err)   take(EV_FRAME_ERR, "frame_err",   data);
         if (blank_seen)  take(EV_BLANK,     "blank_seen",  data);
      end
   end

   // ---- serial BFM: disp_clock period is six system clocks ----
   task automatic half();
      repeat (3) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      disp_clock    = 1'b0;
      disp_data_out = b;
      half();
      disp_clock    = 1'b1;
      half();
   endtask

   task automatic begin_xfer(input logic rs);
      disp_rs = rs;
      half();
      disp_ce_b = 1'b0;
      half();
   endtask

   task automatic end_xfer();
      disp_clock = 1'b0;
      half();
      disp_ce_b = 1'b1;
      half();
      half();
   endtask

   task automatic send_char(input logic [39:0] dots);
      for (int i = 39; i >= 0; i--) send_bit(dots[i]);
   endtask

   // Chars below blank_below are sent blank, char flip_c gets dot 39 inverted,
   // and extra additional glyph chars are appended after char 0.
   task automatic send_frame_x(input logic [63:0] v, input int extra, input int flip_c,
                               input int blank_below);
      logic [39:0] dots;
      begin_xfer(1'b0);
      for (int c = 15; c >= 0; c--) begin
         dots = glyph(v[4*c +: 4]);
         if (c < blank_below) dots = '0;
         if (c == flip_c) dots[39] = ~dots[39];
         send_char(dots);
      end
      for (int x = 0; x < extra; x++) send_char(glyph(4'h5));
      end_xfer();
   endtask

   task automatic send_ctrl(input logic [31:0] w, input int nbits);
      begin_xfer(1'b1);
      for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
      end_xfer();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; disp_clock = 1'b0; disp_data_out = 1'b0; disp_rs = 1'b0;
      disp_ce_b = 1'b1; disp_reset_b = 1'b0;
      exp_data = '0; exp_ctrl = '0;
      repeat (4) @(negedge clk);
      check("reset_data", data, 64'h0);
      check("reset_control", {32'h0, control}, 64'h0);
      check("reset_pulses", 64'({frame_valid, frame_err, blank_seen, ctrl_valid, ctrl_err}), 64'h0);
      reset = 1'b0;
      half();
      disp_reset_b = 1'b1;
      half();

      // Power-up sequence of the labkit driver: control word, blank frame, data frame.
      exp_ctrl = 32'h7F7F7F7F;
      expect_ev(EV_CTRL, {32'h0, exp_ctrl});
      send_ctrl(32'h7F7F7F7F, 32);
      drain("init_ctrl");
      expect_ev(EV_BLANK, exp_data);
      send_frame_x(64'h0, 0, -1, 16);
      drain("blank_frame");
      exp_data = 64'h0123456789ABCDEF;
      expect_ev(EV_FRAME, exp_data);
      send_frame_x(64'h0123456789ABCDEF, 0, -1, 0);
      drain("frame_0123");
      check("data_0123", data, exp_data);

      // Driver switches its value.
      exp_data = 64'hFEDCBA9876543210;
      expect_ev(EV_FRAME, exp_data);
      send_frame_x(64'hFEDCBA9876543210, 0, -1, 0);
      drain("frame_fedc");

      // One flipped dot in char 7 rejects the frame.
      expect_ev(EV_FRAME_ERR, exp_data);
      send_frame_x(64'h0123456789ABCDEF, 0, 7, 0);
      drain("flip_char7");
      check("data_after_flip", data, exp_data);

      // Half glyphs, half blank.
      expect_ev(EV_FRAME_ERR, exp_data);
      send_frame_x(64'h13579BDF02468ACE, 0, -1, 8);
      drain("mixed_blank");

      // Short then full control write.
      expect_ev(EV_CTRL_ERR, {32'h0, exp_ctrl});
      send_ctrl(32'h12345678, 31);
      drain("ctrl_31");
      check("control_after_31", {32'h0, control}, {32'h0, exp_ctrl});
      exp_ctrl = 32'h12345678;
      expect_ev(EV_CTRL, {32'h0, exp_ctrl});
      send_ctrl(32'h12345678, 32);
      drain("ctrl_32");

      // Chip-enable toggle with no clocks while idle.
      snap = pulses_seen;
      disp_ce_b = 1'b0;
      repeat (10) @(negedge clk);
      disp_ce_b = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_ce_no_pulse", 64'(pulses_seen), 64'(snap));

      // Display reset after 200 dots, then a full frame.
      snap = pulses_seen;
      begin_xfer(1'b0);
      for (int c = 0; c < 5; c++) send_char(glyph(4'h3));
      disp_clock = 1'b0;
      half();
      disp_reset_b = 1'b0;
      half();
      disp_ce_b = 1'b1;
      half(); half();
      disp_reset_b = 1'b1;
      half(); half();
      check("abort_no_pulse", 64'(pulses_seen), 64'(snap));
      exp_data = 64'hAAAAAAAAAAAAAAAA;
      expect_ev(EV_FRAME, exp_data);
      send_frame_x(64'hAAAAAAAAAAAAAAAA, 0, -1, 0);
      drain("frame_aaaa");

      // System reset in the middle of a frame.
      begin_xfer(1'b0);
      send_char(glyph(4'h9));
      send_char(glyph(4'h1));
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      disp_clock = 1'b0;
      half();
      reset = 1'b1;
      @(negedge clk);
      check("midreset_data", data, 64'h0);
      check("midreset_control", {32'h0, control}, 64'h0);
      check("midreset_pulses", 64'({frame_valid, frame_err, blank_seen, ctrl_valid, ctrl_err}), 64'h0);
      disp_ce_b = 1'b1;
      half(); half();
      reset = 1'b0;
      exp_data = '0;
      exp_ctrl = '0;
      half(); half();
      exp_data = 64'h0F1E2D3C4B5A6978;
      expect_ev(EV_FRAME, exp_data);
      send_frame_x(64'h0F1E2D3C4B5A6978, 0, -1, 0);
      drain("frame_after_reset");

      // 17 characters overflow the frame.
      expect_ev(EV_FRAME_ERR, exp_data);
      send_frame_x(64'h0123456789ABCDEF, 1, -1, 0);
      drain("overflow_17");
      check("data_after_overflow", data, exp_data);
      check("control_final", {32'h0, control}, {32'h0, exp_ctrl});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
